// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state type and default timing constants for button_conditioner
package button_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int LONG_CYCLES_DEF     = 1024;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw pin in, conditioned level and event pulses out
interface button_conditioner_if;

    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_press
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_press
    );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer, async active-low reset to 0
module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced pushbutton with press/release/long-press pulses; BUTTON_LONG_PRESS_EN enables long press
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    button_conditioner_if.slave  btn
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    btn_state_t    state, state_nxt;
    logic [DW-1:0] db_cnt, db_cnt_nxt;
    logic          sync;
    logic          level_nxt;
    logic          press_nxt;
    logic          release_nxt;

    sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn.btn_raw),
        .q       (sync)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            db_cnt            <= '0;
            btn.btn_level     <= 1'b0;
            btn.press_pulse   <= 1'b0;
            btn.release_pulse <= 1'b0;
        end else begin
            state             <= state_nxt;
            db_cnt            <= db_cnt_nxt;
            btn.btn_level     <= level_nxt;
            btn.press_pulse   <= press_nxt;
            btn.release_pulse <= release_nxt;
        end
    end

    // The first differing sample moves into a WAIT state; DEBOUNCE_CYCLES more confirm it.
    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        unique case (state)
            IDLE: begin
                if (sync) begin
                    state_nxt  = PRESS_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_nxt  = IDLE;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt  = PRESSED;
                    db_cnt_nxt = '0;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_nxt  = RELEASE_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_nxt  = PRESSED;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt  = IDLE;
                    db_cnt_nxt = '0;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                db_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        press_nxt   = (state == PRESS_WAIT)   && (state_nxt == PRESSED);
        release_nxt = (state == RELEASE_WAIT) && (state_nxt == IDLE);
        level_nxt   = (state_nxt == PRESSED)  || (state_nxt == RELEASE_WAIT);
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_PRE = LW'(LONG_CYCLES - 2);

    logic [LW-1:0] long_cnt;

    // Held (not cleared) across RELEASE_WAIT so a bounce cannot retrigger long_press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            long_cnt       <= '0;
            btn.long_press <= 1'b0;
        end else begin
            btn.long_press <= 1'b0;
            if (press_nxt) begin
                long_cnt <= '0;
            end else if ((state == PRESSED) && (long_cnt != LONG_MAX)) begin
                long_cnt       <= long_cnt + 1'b1;
                btn.long_press <= (long_cnt == LONG_PRE);
            end
        end
    end
`else
    logic unused_long_cycles;

    assign unused_long_cycles = ^LONG_CYCLES;
    assign btn.long_press     = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized bench for button_conditioner against a run-length reference model
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 20;
`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (bif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    // Values seen at each rising edge, consumed by the model on the following falling edge.
    logic raw_at_edge = 1'b0;
    logic rst_at_edge = 1'b0;
    always @(posedge clk) begin
        raw_at_edge <= bif.btn_raw;
        rst_at_edge <= reset_n;
    end

    // Model: the accepted level flips once the synchronized input has disagreed with it
    // for D+1 consecutive edges; press age counts edges spent stable-pressed.
    bit d1, d2, m_level;
    int run, age;
    bit e_press, e_rel, e_long;

    initial begin
        forever begin
            @(negedge clk);
            e_press = 0; e_rel = 0; e_long = 0;
            if (!rst_at_edge) begin
                d1 = 0; d2 = 0; m_level = 0; run = 0; age = 0;
            end else begin
                bit s;
                bit stable_pressed;
                s  = d2;
                d2 = d1;
                d1 = raw_at_edge;
                stable_pressed = m_level && (run == 0);
                if (s != m_level) run++;
                else run = 0;
                if (run == D + 1) begin
                    m_level = !m_level;
                    run = 0;
                    if (m_level) begin
                        e_press = 1;
                        age = 0;
                    end else begin
                        e_rel = 1;
                    end
                end else if (stable_pressed && age < L) begin
                    age++;
                    if (age == L - 1 && LONG_EN) e_long = 1;
                end
            end
            check("btn_level", bif.btn_level, m_level);
            check("press_pulse", bif.press_pulse, e_press);
            check("release_pulse", bif.release_pulse, e_rel);
            check("long_press", bif.long_press, e_long);
            check("pulse_exclusive",
                  32'(($countones({bif.press_pulse, bif.release_pulse, bif.long_press}) <= 1)), 1);
        end
    end

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            bif.btn_raw = v;
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_level", bif.btn_level, 0);
        check("rst_press", bif.press_pulse, 0);
        check("rst_release", bif.release_pulse, 0);
        check("rst_long", bif.long_press, 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        bit lvl;
        int len;
        bif.btn_raw = 1'b0;
        repeat (3) @(negedge clk);
        check("init_level", bif.btn_level, 0);
        check("init_press", bif.press_pulse, 0);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // Clean long press, short bounce, glitch during press, reset while held.
        hold(0, 5);  hold(1, 45); hold(0, 12);
        hold(1, 3);  hold(0, 10);
        hold(1, 12); hold(0, 2);  hold(1, 10); hold(0, 12);
        hold(1, 12);
        pulse_reset();
        hold(1, 15); hold(0, 12);

        lvl = 1'b1;
        for (int seg = 0; seg < 180; seg++) begin
            case ($urandom_range(0, 3))
                0: len = $urandom_range(1, D);
                1: len = $urandom_range(D, D + 2);
                2: len = $urandom_range(D + 3, 12);
                default: len = $urandom_range(25, 45);
            endcase
            if ($urandom_range(0, 19) == 0) begin
                hold(lvl, len / 2 + 1);
                pulse_reset();
                hold(lvl, len);
            end else begin
                hold(lvl, len);
            end
            lvl = !lvl;
        end
        hold(0, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
